// File: rtl/eval_seq_pkg.sv
// Shared types and default constants for the eval kernel sequencer.
// Data width, default timing parameters and the sequencer power-state encoding.
package eval_seq_pkg;

  localparam int EVAL_DATA_W      = 8;
  localparam int EVAL_LATENCY     = 2;
  localparam int EVAL_IDLE_CYCLES = 8;
  localparam int EVAL_WAKE_CYCLES = 2;

  typedef enum logic [1:0] {
    SLEEP = 2'd0,
    WAKE  = 2'd1,
    RUN   = 2'd2
  } eval_state_e;

endpackage

// File: rtl/eval_result_fifo.sv
// Synchronous result FIFO with occupancy count; push and pop may coincide at any fill level.
// The head is forced to zero while empty so the output is clean out of reset.
module eval_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eval_kernel_sequencer.sv
// Initiator for the gated eval kernel: credit-based operand issue, in-order result
// collection, and wake/idle power control of the kernel enable.
module eval_kernel_sequencer
  import eval_seq_pkg::*;
#(
  parameter int LATENCY     = EVAL_LATENCY,
  parameter int IDLE_CYCLES = EVAL_IDLE_CYCLES,
  parameter int WAKE_CYCLES = EVAL_WAKE_CYCLES,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EVAL_DATA_W-1:0] in_a,
  input  logic [EVAL_DATA_W-1:0] in_b,
  output logic [EVAL_DATA_W-1:0] k_data1,
  output logic [EVAL_DATA_W-1:0] k_data2,
  output logic                   kernel_enable,
  input  logic [EVAL_DATA_W-1:0] k_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EVAL_DATA_W-1:0] out_data,
  output eval_state_e            state_dbg
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both 1;
  // a source holds its payload stable while valid is high and ready is low, and
  // ready never depends combinationally on the same interface's valid.

  eval_state_e       state_q, state_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [LATENCY:0]  vpipe_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;
  int                inflight;
  logic              credit_ok;
  logic              accept;

  always_comb begin
    inflight = 0;
    for (int i = 0; i <= LATENCY; i++) begin
      if (vpipe_q[i]) begin
        inflight = inflight + 1;
      end
    end
  end

  // Every issued operand reserves a FIFO slot until its result is popped.
  assign credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
  assign in_ready  = (state_q == RUN) && credit_ok;
  assign accept    = in_valid && in_ready;
  assign fifo_pop  = out_valid && out_ready;
  assign state_dbg = state_q;

  always_comb begin
    state_d       = state_q;
    wake_cnt_d    = wake_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    kernel_enable = 1'b0;
    unique case (state_q)
      SLEEP: begin
        if (in_valid) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_W'(WAKE_CYCLES - 1);
        end
      end
      WAKE: begin
        kernel_enable = 1'b1;
        if (wake_cnt_q == '0) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - WAKE_W'(1);
        end
      end
      RUN: begin
        kernel_enable = 1'b1;
        if (accept || (inflight != 0)) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
          // This edge is the IDLE_CYCLES-th empty cycle: gate the kernel now.
          state_d    = SLEEP;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      default: state_d = SLEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SLEEP;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      vpipe_q    <= '0;
      k_data1    <= '0;
      k_data2    <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      vpipe_q    <= {vpipe_q[LATENCY-1:0], accept};
      if (accept) begin
        k_data1 <= in_a;
        k_data2 <= in_b;
      end
    end
  end

  eval_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVAL_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vpipe_q[LATENCY]),
    .push_data (k_result),
    .pop       (fifo_pop),
    .head      (out_data),
    .valid     (out_valid),
    .count     (fifo_count)
  );

endmodule

// File: doc/eval_kernel_sequencer.md
# eval_kernel_sequencer

Initiator side of the gated eval kernel: accepts operand pairs on a valid/ready stream, drives the kernel's two 8-bit data inputs and its `kernel_enable`, and collects the kernel's `result`. Results are returned in order on an output stream. The block issues operands only while it holds output-FIFO space for their results, so it never drops a result. It owns kernel power: it wakes the kernel on demand and gates it off after a programmable idle period.

## Interface
Parameters:
- `LATENCY`, 2: cycles from operands on `k_data1`/`k_data2` to the matching `k_result`.
- `IDLE_CYCLES`, 8: empty-pipe idle cycles in RUN before returning to SLEEP.
- `WAKE_CYCLES`, 2: cycles `kernel_enable` is high before the first issue.
- `FIFO_DEPTH`, 4: result FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand pair available.
- `in_ready`  out  1: operand pair accepted when `in_valid && in_ready`.
- `in_a`  in  8: operand for kernel `data_in1`.
- `in_b`  in  8: operand for kernel `data_in2`.
- `k_data1`  out  8: registered drive of kernel `data_in1`.
- `k_data2`  out  8: registered drive of kernel `data_in2`.
- `kernel_enable`  out  1: kernel enable / clock-gate control.
- `k_result`  in  8: kernel result.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: consumer pops the head when `out_valid && out_ready`.
- `out_data`  out  8: FIFO head.

## Operation
- Reset: state SLEEP; `in_ready`, `kernel_enable`, `out_valid`, `k_data1`, `k_data2` and `out_data` are 0; FIFO empty; valid pipe clear; all counters 0.
- **SLEEP**: `kernel_enable`=0 and `in_ready`=0.
  - `in_valid`=1 → WAKE, with the wake counter loaded to `WAKE_CYCLES`-1.
  - The FIFO keeps draining to the consumer in this state.
- **WAKE**: `kernel_enable`=1 and `in_ready`=0.
  - The counter decrements each cycle.
  - When the counter is 0 → RUN.
- **RUN**: `kernel_enable`=1.
  - `in_ready` = (fifo_count + inflight < `FIFO_DEPTH`). `inflight` is the popcount of the valid pipe.
  - On acceptance: `k_data1`←`in_a`, `k_data2`←`in_b`, and a 1 is pushed into the `LATENCY+1`-bit valid pipe. Otherwise `k_data*` hold their values and a 0 is pushed.
  - Idle counter: cleared on any acceptance or while inflight≠0; otherwise increments.
  - When it reaches `IDLE_CYCLES` → SLEEP.
- Capture: when the last valid-pipe bit is 1, `k_result` is written to the FIFO that cycle. The credit rule guarantees the FIFO is never full at a capture.
- FIFO: push and pop in the same cycle are allowed at any count, including full and empty. `out_data` holds the head. Its value is don't-care while `out_valid`=0.
- In-order delivery; no reordering and no loss.

## Timing
- Acceptance at edge t → `k_data*` valid in cycle t+1 → `k_result` sampled in cycle t+1+`LATENCY` → `out_valid`=1 in cycle t+2+`LATENCY`.
  - This is 4 cycles with defaults, when the FIFO is empty.
- Throughput: one operand per cycle while credits remain.
- Wake: the first `in_valid` seen in SLEEP gives `in_ready`=1 exactly `WAKE_CYCLES`+1 cycles later.
- Sleep: `kernel_enable` falls `IDLE_CYCLES` cycles after the pipe empties with no new acceptance.
- `rst` mid-operation: in-flight results and FIFO contents are discarded; all outputs return to reset values on the next edge.

## Structure
- Package `eval_seq_pkg`:
  - state enum (SLEEP, WAKE, RUN);
  - default constants `EVAL_LATENCY`, `EVAL_IDLE_CYCLES`, `EVAL_WAKE_CYCLES`;
  - the data width constant 8.
- Sub-module `eval_result_fifo`: synchronous FIFO parameterised on depth and width, exposing `count`, with `clk`/`rst` as above.
- Top level: FSM, counters, valid pipe, credit logic.

## Test plan
Benches use a mock kernel with `result` = `data_in1`+`data_in2` (mod 256), delayed `LATENCY`.
- Cold start: with defaults, `in_valid`=1, `in_a`=3, `in_b`=4 → `in_ready` rises 3 cycles later; after acceptance, `out_valid`=1 with `out_data`=7 exactly 4 cycles later.
- Back-pressure:
  - With `out_ready`=0, present 6 pairs (i, i+1) for i=0..5 → exactly 4 are accepted and `in_ready` stays 0.
  - Then raise `out_ready` → outputs 1, 3, 5, 7, 9, 11 in order with no gaps in the input.
- Idle gating: after the last result is captured, `kernel_enable` stays 1 for 8 cycles with no input, then 0; state SLEEP; FIFO still drains.
- Wrap and overflow: `in_a`=200, `in_b`=100 → `out_data`=44.
- Full FIFO with simultaneous push and pop: streaming with `out_ready` toggling every cycle → no lost or duplicated results over 100 random pairs; the scoreboard matches.
- Reset mid-flight: assert `rst` for 1 cycle with 2 ops in flight and 2 in the FIFO → next cycle `out_valid`=0, `kernel_enable`=0, `in_ready`=0; no stale result ever appears afterwards.
